// File: rtl/matvec_stream_host.sv
// Word-serial host bridge for the 4x4 matrix-vector accelerator: loads 20 operand words, issues the job, streams 4 results.
// Optional MATVEC_FRAME_CHECK_EN adds s_last framing with a one-cycle frame_err pulse on a misframed job.
module matvec_stream_host #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic s_valid,
    output logic s_ready,
    input  real  s_data,
`ifdef MATVEC_FRAME_CHECK_EN
    input  logic s_last,
    output logic frame_err,
`endif
    output logic acc_i_valid,
    input  logic acc_i_ready,
    output real  mat_0_0,
    output real  mat_0_1,
    output real  mat_0_2,
    output real  mat_0_3,
    output real  mat_1_0,
    output real  mat_1_1,
    output real  mat_1_2,
    output real  mat_1_3,
    output real  mat_2_0,
    output real  mat_2_1,
    output real  mat_2_2,
    output real  mat_2_3,
    output real  mat_3_0,
    output real  mat_3_1,
    output real  mat_3_2,
    output real  mat_3_3,
    output real  vector_0,
    output real  vector_1,
    output real  vector_2,
    output real  vector_3,
    input  logic acc_o_valid,
    output logic acc_o_ready,
    input  real  product_0,
    input  real  product_1,
    input  real  product_2,
    input  real  product_3,
    output logic r_valid,
    input  logic r_ready,
    output real  r_data,
    output logic r_last,
    output logic error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [4:0]      r_cnt;
    logic [1:0]      r_idx;
    logic [TW-1:0]   r_tmo;
    logic            r_acc_i_valid;
    logic            r_rlast;
    real             r_rdata;
    real             r_op [20];
    real             r_prod [4];

    logic w_s_fire;
    logic w_last_word;
    logic w_frame_bad;
    logic w_word_ok;
    logic w_tmo_hit;

    assign w_s_fire    = s_valid && (r_state == S_LOAD);
    assign w_last_word = (r_cnt == 5'd19);
`ifdef MATVEC_FRAME_CHECK_EN
    assign w_frame_bad = w_s_fire && (s_last != w_last_word);
`else
    assign w_frame_bad = 1'b0;
`endif
    assign w_word_ok   = w_s_fire && !w_frame_bad;
    assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        acc_o_ready  = 1'b0;
        r_valid      = 1'b0;
        error        = 1'b0;
        case (r_state)
            S_LOAD: begin
                s_ready = 1'b1;
                if (w_word_ok && w_last_word) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_acc_i_valid && acc_i_ready) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                acc_o_ready = 1'b1;
                // A result arriving on the timeout cycle still counts.
                if (acc_o_valid)    w_state_next = S_SEND;
                else if (w_tmo_hit) w_state_next = S_ERROR;
            end
            S_SEND: begin
                r_valid = 1'b1;
                if (r_ready && (r_idx == 2'd3)) w_state_next = S_LOAD;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                w_state_next = S_ERROR;
            end
        endcase
    end

    // Operand word k lands in slot k; slots only move while loading.
    for (genvar gi = 0; gi < 20; gi++) begin : g_op
        always_ff @(posedge clk) begin
            if (rst) begin
                r_op[gi] <= 0.0;
            end else if (w_word_ok && (r_cnt == 5'(gi))) begin
                r_op[gi] <= s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_LOAD;
            r_cnt         <= 5'd0;
            r_idx         <= 2'd0;
            r_tmo         <= '0;
            r_acc_i_valid <= 1'b0;
            r_rlast       <= 1'b0;
            r_rdata       <= 0.0;
            for (int i = 0; i < 4; i++) r_prod[i] <= 0.0;
        end else begin
            r_state       <= w_state_next;
            r_acc_i_valid <= (w_state_next == S_ISSUE);
            case (r_state)
                S_LOAD: begin
                    if (w_frame_bad)    r_cnt <= 5'd0;
                    else if (w_word_ok) r_cnt <= w_last_word ? 5'd0 : r_cnt + 5'd1;
                end
                S_WAIT: begin
                    if (acc_o_valid) begin
                        r_prod[0] <= product_0;
                        r_prod[1] <= product_1;
                        r_prod[2] <= product_2;
                        r_prod[3] <= product_3;
                        r_rdata   <= product_0;
                        r_rlast   <= 1'b0;
                        r_idx     <= 2'd0;
                        r_tmo     <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_SEND: begin
                    if (r_ready) begin
                        if (r_idx == 2'd3) begin
                            r_idx   <= 2'd0;
                            r_rlast <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_rdata <= r_prod[r_idx + 2'd1];
                            r_rlast <= (r_idx == 2'd2);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MATVEC_FRAME_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) frame_err <= 1'b0;
        else     frame_err <= w_frame_bad;
    end
`endif

    assign acc_i_valid = r_acc_i_valid;
    assign r_data      = r_rdata;
    assign r_last      = r_rlast;

    assign mat_0_0  = r_op[0];
    assign mat_0_1  = r_op[1];
    assign mat_0_2  = r_op[2];
    assign mat_0_3  = r_op[3];
    assign mat_1_0  = r_op[4];
    assign mat_1_1  = r_op[5];
    assign mat_1_2  = r_op[6];
    assign mat_1_3  = r_op[7];
    assign mat_2_0  = r_op[8];
    assign mat_2_1  = r_op[9];
    assign mat_2_2  = r_op[10];
    assign mat_2_3  = r_op[11];
    assign mat_3_0  = r_op[12];
    assign mat_3_1  = r_op[13];
    assign mat_3_2  = r_op[14];
    assign mat_3_3  = r_op[15];
    assign vector_0 = r_op[16];
    assign vector_1 = r_op[17];
    assign vector_2 = r_op[18];
    assign vector_3 = r_op[19];
endmodule
